// File: rtl/aes_key_schedule.sv
// AES-128 key expansion engine.
// Expands a 128-bit cipher key into round keys rk[0..NROUNDS], one round key per clock.
// SubWord is performed by an external S-box:
//   - SUBW_IN carries RotWord of the previous round key's last word.
//   - SUBW_OUT returns SubWord(SUBW_IN) combinationally.
// Round keys are readable at any time through RK_IDX/RK_DATA.
//
// Optional feature: define AES_KS_CACHE_EN to add a last-key register and a valid flag.
// With the cache enabled, a START in IDLE with the same key as the last completed expansion
// skips straight to DONE and leaves the stored round keys untouched.
//
// Handshake: START is a level request that is only looked at in IDLE.
// DONE is held while START stays high, and the FSM returns to IDLE on the first edge with START low.
// The FSM state is visible internally as state_q: IDLE=0, EXPAND=1, DONE=2.
module aes_key_schedule #(
    parameter int NROUNDS = 10  // only 10 (AES-128) is supported
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [127:0] KEY,
    output logic         BUSY,
    output logic         DONE,
    input  logic [3:0]   RK_IDX,
    output logic [127:0] RK_DATA,
    output logic [31:0]  SUBW_IN,
    input  logic [31:0]  SUBW_OUT
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rk_q [0:NROUNDS];
    logic [127:0] rk_d [0:NROUNDS];
    logic [127:0] prev_rk;
    logic [127:0] next_rk;
    logic [31:0]  temp_w;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic         cache_hit;

`ifdef AES_KS_CACHE_EN
    logic [127:0] last_key_q, last_key_d;
    logic         valid_q, valid_d;
`endif

    // Round constant for the round key currently being produced.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Select rk[cnt-1] and drive RotWord of its last word to the S-box while expanding.
    always_comb begin
        prev_rk = '0;
        for (int i = 0; i < NROUNDS; i++) begin
            if (cnt_q == 4'(i + 1)) begin
                prev_rk = rk_q[i];
            end
        end
        if (state_q == ST_EXPAND) begin
            SUBW_IN = {prev_rk[23:0], prev_rk[31:24]};
        end else begin
            SUBW_IN = '0;
        end
    end

    // Next round key from the previous one and the S-box result.
    always_comb begin
        temp_w  = SUBW_OUT ^ {rcon(cnt_q), 24'h0};
        w0_n    = prev_rk[127:96] ^ temp_w;
        w1_n    = prev_rk[95:64]  ^ w0_n;
        w2_n    = prev_rk[63:32]  ^ w1_n;
        w3_n    = prev_rk[31:0]   ^ w2_n;
        next_rk = {w0_n, w1_n, w2_n, w3_n};
    end

`ifdef AES_KS_CACHE_EN
    // A repeated key whose schedule is already stored needs no new expansion.
    always_comb begin
        cache_hit = valid_q && (KEY == last_key_q);
    end
`else
    // No cache: every request expands.
    always_comb begin
        cache_hit = 1'b0;
    end
`endif

    // FSM and round-key next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rk_d    = rk_q;
`ifdef AES_KS_CACHE_EN
        last_key_d = last_key_q;
        valid_d    = valid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (cache_hit) begin
                        state_d = ST_DONE;
                    end else begin
                        rk_d[0] = KEY;
                        cnt_d   = 4'd1;
                        state_d = ST_EXPAND;
`ifdef AES_KS_CACHE_EN
                        // The stored schedule is being replaced; not valid until complete.
                        last_key_d = KEY;
                        valid_d    = 1'b0;
`endif
                    end
                end
            end
            ST_EXPAND: begin
                for (int i = 1; i <= NROUNDS; i++) begin
                    if (cnt_q == 4'(i)) begin
                        rk_d[i] = next_rk;
                    end
                end
                if (cnt_q == 4'(NROUNDS)) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
`ifdef AES_KS_CACHE_EN
                    valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (!START) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset clearing all round keys.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            for (int i = 0; i <= NROUNDS; i++) begin
                rk_q[i] <= '0;
            end
`ifdef AES_KS_CACHE_EN
            last_key_q <= '0;
            valid_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i <= NROUNDS; i++) begin
                rk_q[i] <= rk_d[i];
            end
`ifdef AES_KS_CACHE_EN
            last_key_q <= last_key_d;
            valid_q    <= valid_d;
`endif
        end
    end

    // Combinational round-key read port; indices past the last round key read as zero.
    always_comb begin
        RK_DATA = '0;
        for (int i = 0; i <= NROUNDS; i++) begin
            if (RK_IDX == 4'(i)) begin
                RK_DATA = rk_q[i];
            end
        end
    end

    assign BUSY = (state_q == ST_EXPAND);
    assign DONE = (state_q == ST_DONE);

endmodule
